vnu_serial: RTL and testbench

Parametrised, serial-I/O variable-node update unit for the LDPC decoder. It takes one channel LLR L, then accepts DV check-to-variable messages R one per handshake and stores them. It forms the total L + ΣR at full width and emits DV extrinsic messages Q_i = total − R_i one per handshake, plus the hard decision P. It succeeds the fixed 6-input, 32-bit parallel VNU: degree and width are parameters, I/O is time-multiplexed with valid/ready flow control, and Q is optionally saturated.

---
 rtl/vnu_pkg.sv | 27 ++
 rtl/vnu_msg_buf.sv | 25 ++
 rtl/vnu_serial.sv | 124 ++++++++++++
 tb/tb_vnu_serial.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vnu_pkg.sv
// Shared types and helpers for the serial variable-node update unit.
// Saturating output format is selected in vnu_serial by the VNU_SAT_EN macro.
package vnu_pkg;

   typedef enum logic [1:0] {IDLE, COLLECT, EMIT} vnu_state_t;

   function automatic int vnu_aw(input int dv, input int w);
      return w + $clog2(dv + 1);
   endfunction

   localparam int VNU_DV_DEF = 6;
   localparam int VNU_W_DEF  = 8;
   localparam int VNU_AW_DEF = VNU_W_DEF + $clog2(VNU_DV_DEF + 1);

   // Symmetric clamp of a full-width sum to +/-(2^(w-1)-1); caller truncates to w bits.
   function automatic logic signed [31:0] sat_w(input logic signed [31:0] x, input int w);
      logic signed [31:0] lim;
      lim = (32'sd1 <<< (w - 1)) - 32'sd1;
      if (x > lim)
         return lim;
      else if (x < -lim)
         return -lim;
      else
         return x;
   endfunction

endpackage

// File: rtl/vnu_msg_buf.sv
// DV x W register file holding the check messages of one node update.
// Single write port, combinational read port, no reset.
module vnu_msg_buf #(
   parameter int DV = 6,
   parameter int W  = 8,
   parameter int CW = $clog2(DV)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [CW-1:0] waddr,
   input  logic [W-1:0]  wdata,
   input  logic [CW-1:0] raddr,
   output logic [W-1:0]  rdata
);

   logic [DV-1:0][W-1:0] mem;

   always_ff @(posedge clk) begin
      if (we)
         mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/vnu_serial.sv
// Serial-I/O LDPC variable-node update: collects DV R messages, emits DV Q = total - R_i.
// Define VNU_SAT_EN to clamp Q symmetrically; otherwise Q wraps to W bits.
module vnu_serial
   import vnu_pkg::*;
#(
   parameter int DV = 6,
   parameter int W  = 8,
   parameter int AW = vnu_aw(DV, W)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] l_in,
   input  logic         l_valid,
   input  logic [W-1:0] r_in,
   input  logic         r_valid,
   output logic         r_ready,
   output logic [W-1:0] q_out,
   output logic         q_valid,
   input  logic         q_ready,
   output logic         q_last,
   output logic         p_out,
   output logic         busy
);

   localparam int CW = (DV > 1) ? $clog2(DV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DV - 1);

   vnu_state_t           state;
   logic [CW-1:0]        cnt;
   logic signed [AW-1:0] acc;
   logic signed [AW-1:0] l_x, r_x, b_x, acc_nxt, base, diff;
   logic [CW-1:0]        cnt_inc, raddr;
   logic [W-1:0]         rdata, q_fmt;
   logic                 r_xfer, q_xfer;

   assign r_xfer  = r_valid & r_ready;
   assign q_xfer  = q_valid & q_ready;
   assign cnt_inc = cnt + CW'(1);

   assign l_x     = {{(AW-W){l_in[W-1]}}, l_in};
   assign r_x     = {{(AW-W){r_in[W-1]}}, r_in};
   assign b_x     = {{(AW-W){rdata[W-1]}}, rdata};
   assign acc_nxt = acc + r_x;

   // q_out is registered, so the read port looks one message ahead: buf[0] on
   // the final R transfer, buf[cnt+1] on each Q transfer.
   assign raddr = (state == EMIT && cnt != LAST) ? cnt_inc : '0;
   assign base  = (state == COLLECT) ? acc_nxt : acc;
   assign diff  = base - b_x;

`ifdef VNU_SAT_EN
   assign q_fmt = W'(sat_w(32'(diff), W));
`else
   assign q_fmt = W'(diff);
`endif

   vnu_msg_buf #(.DV(DV), .W(W), .CW(CW)) u_buf (
      .clk   (clk),
      .we    (r_xfer),
      .waddr (cnt),
      .wdata (r_in),
      .raddr (raddr),
      .rdata (rdata)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= '0;
         acc     <= '0;
         r_ready <= 1'b0;
         q_valid <= 1'b0;
         q_last  <= 1'b0;
         busy    <= 1'b0;
         p_out   <= 1'b0;
         q_out   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (l_valid) begin
                  acc     <= l_x;
                  cnt     <= '0;
                  r_ready <= 1'b1;
                  busy    <= 1'b1;
                  state   <= COLLECT;
               end
            end
            COLLECT: begin
               if (r_xfer) begin
                  acc <= acc_nxt;
                  if (cnt == LAST) begin
                     cnt     <= '0;
                     p_out   <= acc_nxt[AW-1];
                     r_ready <= 1'b0;
                     q_valid <= 1'b1;
                     q_out   <= q_fmt;
                     q_last  <= 1'b0;
                     state   <= EMIT;
                  end else begin
                     cnt <= cnt_inc;
                  end
               end
            end
            EMIT: begin
               if (q_xfer) begin
                  if (cnt == LAST) begin
                     cnt     <= '0;
                     q_valid <= 1'b0;
                     q_last  <= 1'b0;
                     busy    <= 1'b0;
                     state   <= IDLE;
                  end else begin
                     cnt    <= cnt_inc;
                     q_out  <= q_fmt;
                     q_last <= (cnt_inc == LAST);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_vnu_serial.sv
// Scoreboard bench for vnu_serial (DV=6, W=8): directed plan scenarios plus randomized updates.
module tb_vnu_serial;

   localparam int DV = 6;
   localparam int W  = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic [W-1:0] l_in, r_in, q_out;
   logic         l_valid, r_valid, r_ready, q_valid, q_ready, q_last, p_out, busy;

   typedef struct {
      int q;
      bit last;
      bit p;
   } exp_t;

   exp_t sb[$];
   int   total_n = 0;
   int   bad_n   = 0;
   int   cyc     = 0;
   int   qmode   = 0;
   int   t_acc   = 0;
   bit   busy_chk = 0;
   bit   hold_chk = 0;
   logic [W-1:0] held_q;
   logic         held_last;

   vnu_serial #(.DV(DV), .W(W)) dut (
      .clk     (clk),
      .rst     (rst),
      .l_in    (l_in),
      .l_valid (l_valid),
      .r_in    (r_in),
      .r_valid (r_valid),
      .r_ready (r_ready),
      .q_out   (q_out),
      .q_valid (q_valid),
      .q_ready (q_ready),
      .q_last  (q_last),
      .p_out   (p_out),
      .busy    (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      total_n++;
      if (act != exp) begin
         bad_n++;
         $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int fmt(input int v);
`ifdef VNU_SAT_EN
      if (v > 127) return 127;
      if (v < -127) return -127;
      return v;
`else
      logic signed [7:0] t;
      int vv;
      vv = v;
      t = vv[7:0];
      return int'(t);
`endif
   endfunction

   // Reference: total = L + sum(R); Q_i = fmt(total - R_i); P = sign of total.
   task automatic push_expected(input int l, input int r[DV]);
      int   tot;
      exp_t e;
      tot = l;
      foreach (r[i]) tot += r[i];
      for (int i = 0; i < DV; i++) begin
         e.q    = fmt(tot - r[i]);
         e.last = (i == DV - 1);
         e.p    = (tot < 0);
         sb.push_back(e);
      end
   endtask

   initial begin
      q_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (qmode)
            0:       q_ready = 1'b1;
            1:       q_ready = ~q_ready;
            default: q_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   // Monitor: compares every Q transfer against the scoreboard head.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst) begin
            hold_chk = 0;
            busy_chk = 0;
         end else begin
            if (busy_chk) begin
               check("busy_after_last_q", busy, 0);
               busy_chk = 0;
            end
            if (hold_chk && q_valid) begin
               check("q_hold_value", q_out, held_q);
               check("q_hold_last", q_last, held_last);
            end
            hold_chk = 0;
            if (q_valid) begin
               if (q_ready) begin
                  if (sb.size() == 0) begin
                     check("unexpected_q", 1, 0);
                  end else begin
                     e = sb.pop_front();
                     check("q_value", int'($signed(q_out)), e.q);
                     check("q_last", q_last, e.last);
                     check("p_out", p_out, e.p);
                     if (e.last) busy_chk = 1;
                  end
               end else begin
                  hold_chk  = 1;
                  held_q    = q_out;
                  held_last = q_last;
               end
            end
         end
      end
   end

   task automatic wait_idle();
      int n;
      n = 0;
      while (busy && n < 400) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (busy) check("idle_timeout", 1, 0);
   endtask

   task automatic check_reset_outputs();
      check("rst_r_ready", r_ready, 0);
      check("rst_q_valid", q_valid, 0);
      check("rst_q_last", q_last, 0);
      check("rst_busy", busy, 0);
      check("rst_p_out", p_out, 0);
      check("rst_q_out", q_out, 0);
   endtask

   // Drives one update; abort asserts rst after the third R transfer.
   task automatic run_update(input int l, input int r[DV], input int gap, input bit spur, input bit abort);
      int n;
      wait_idle();
      if (!abort) push_expected(l, r);
      l_in    = W'(l);
      l_valid = 1'b1;
      @(posedge clk);
      #1;
      t_acc   = cyc;
      l_valid = 1'b0;
      check("r_ready_after_l", r_ready, 1);
      for (int i = 0; i < DV; i++) begin
         for (int g = 0; g < gap; g++) begin
            r_valid = 1'b0;
            r_in    = W'($urandom);
            if (spur && i == 2 && g == 0) begin
               l_valid = 1'b1;
               l_in    = W'($urandom);
            end
            @(posedge clk);
            #1;
            l_valid = 1'b0;
         end
         r_in    = W'(r[i]);
         r_valid = 1'b1;
         n = 0;
         while (!r_ready && n < 400) begin
            @(posedge clk);
            #1;
            n++;
         end
         if (!r_ready) check("r_ready_timeout", 1, 0);
         @(posedge clk);
         #1;
         r_valid = 1'b0;
         if (abort && i == 2) begin
            rst = 1'b1;
            @(negedge clk);
            check_reset_outputs();
            @(posedge clk);
            #1;
            rst = 1'b0;
            return;
         end
      end
      check("q_valid_latency", q_valid, 1);
   endtask

   initial begin
      int s1[DV] = '{1, 2, 3, 4, 5, 6};
      int s2[DV] = '{127, 127, 127, 127, 127, 127};
      int s3[DV] = '{2, -3, 0, 0, 0, 0};
      int rr[DV];
      int t0, n;

      rst = 1'b1; l_valid = 1'b0; r_valid = 1'b0; l_in = '0; r_in = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_reset_outputs();
      @(posedge clk);
      #1;
      rst = 1'b0;

      qmode = 0;
      run_update(10, s1, 0, 0, 0);
      t0 = t_acc;
      run_update(127, s2, 0, 0, 0);
      check("min_period", t_acc - t0, 2 * DV + 1);
      run_update(-20, s3, 0, 0, 0);

      wait_idle();
      qmode = 1;
      run_update(10, s1, 0, 0, 0);
      wait_idle();
      qmode = 0;
      run_update(10, s1, 2, 1, 0);
      run_update(10, s1, 0, 0, 1);
      run_update(10, s1, 0, 0, 0);

      for (int k = 0; k < 20; k++) begin
         wait_idle();
         qmode = 2;
         for (int i = 0; i < DV; i++) rr[i] = $urandom_range(0, 255) - 128;
         run_update($urandom_range(0, 255) - 128, rr, $urandom_range(0, 2), 1'($urandom_range(0, 1)), 0);
      end

      n = 0;
      while (sb.size() != 0 && n < 1000) begin
         @(posedge clk);
         n++;
      end
      check("scoreboard_drained", sb.size(), 0);
      repeat (2) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total_n, bad_n);
      $finish;
   end

endmodule
